// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Brief    : Load/store unit acting as initiator toward a word-addressed data
//            memory. Turns byte/half/word CPU accesses into single-word
//            read/write strobes, using read-modify-write for sub-word stores,
//            and returns sign/zero-extended load data with an error flag.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU request side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    // CPU response side
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    // Data memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Access size encodings carried in req_op[1:0]
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and registered request
    // ------------------------------------------------------------------
    state_t              state_q;
    logic                we_q;        // request is a store
    logic [2:0]          op_q;        // size + unsigned flag
    logic [1:0]          addr_lo_q;   // byte offset within the word
    logic [15:0]         wdata_q;     // right-aligned sub-word store data

    // Registered outputs
    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [31:0]         resp_rdata_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;

    // ------------------------------------------------------------------
    // Acceptance-time decode of the incoming request
    // ------------------------------------------------------------------
    logic [1:0]           w_size;
    logic [31-ADDR_W-2:0] w_addr_hi;
    logic [ADDR_W-1:0]    w_word_addr;
    logic                 w_err;
    logic                 w_needs_read;

    assign w_size      = req_op[1:0];
    assign w_addr_hi   = req_addr[31:ADDR_W+2];
    assign w_word_addr = req_addr[ADDR_W+1:2];

    // Error priority: illegal size, half misaligned, word misaligned, range.
    // All terms are OR-ed since any one suppresses the memory access.
    assign w_err = (w_size == SIZE_X)
                || ((w_size == SIZE_H) && req_addr[0])
                || ((w_size == SIZE_W) && (req_addr[1:0] != 2'b00))
                || (w_addr_hi != '0);

    // Loads always read; stores read first only when they do not cover the word
    assign w_needs_read = !req_we || (w_size != SIZE_W);

    // ------------------------------------------------------------------
    // Load lane selection with sign/zero extension (little-endian lanes)
    // ------------------------------------------------------------------
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [2:0]  op,
        input logic [1:0]  lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (op[1:0])
            SIZE_B:  load_extract = op[2] ? {24'h000000, b} : {{24{b[7]}}, b};
            SIZE_H:  load_extract = op[2] ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Sub-word store: replace the addressed lane inside the fetched word
    // ------------------------------------------------------------------
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lo,
        input logic [15:0] wd
    );
        store_merge = word;
        if (size == SIZE_B) begin
            case (lo)
                2'd0:    store_merge[7:0]   = wd[7:0];
                2'd1:    store_merge[15:8]  = wd[7:0];
                2'd2:    store_merge[23:16] = wd[7:0];
                default: store_merge[31:24] = wd[7:0];
            endcase
        end else if (size == SIZE_H) begin
            if (lo[1]) begin
                store_merge[31:16] = wd;
            end else begin
                store_merge[15:0]  = wd;
            end
        end
    endfunction

    // Control FSM: all outputs are registered and set on the edge entering
    // the state that owns them, so they behave as Moore decodes of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            op_q         <= 3'b000;
            addr_lo_q    <= 2'b00;
            wdata_q      <= 16'h0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        op_q        <= req_op;
                        addr_lo_q   <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        req_ready_q <= 1'b0;
                        if (w_err) begin
                            // No memory traffic; report immediately
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else if (w_needs_read) begin
                            state_q    <= S_READ;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= w_word_addr;
                        end else begin
                            // Full-word store needs no merge
                            state_q     <= S_WRITE;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= w_word_addr;
                            mem_wdata_q <= req_wdata;
                        end
                    end
                end

                S_READ: begin
                    mem_read_q <= 1'b0;
                    if (we_q) begin
                        // Memory data is combinational: merge it this edge
                        state_q     <= S_WRITE;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= store_merge(mem_rdata, op_q[1:0],
                                                   addr_lo_q, wdata_q);
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_extract(mem_rdata, op_q, addr_lo_q);
                    end
                end

                S_WRITE: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                end

                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_master
// Brief    : Directed, table-driven bench for lsu_mem_master with a 32-word
//            memory model, plus hand-written back-to-back and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preloaded while tb_init is high, then written by the DUT
    logic        tb_init;
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h0123_4567;
            mem[3]  <= 32'h8899_AABB;
            mem[7]  <= 32'h7654_3210;
            mem[31] <= 32'hA5A5_5A5A;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    int n_vec;
    int n_chk;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;   // compare resp_rdata
        logic [31:0] rdata;
        logic        err;
        int          lat;      // accepting edge = cycle 0
        int          nrd;
        int          nwr;
        logic [31:0] wword;    // expected mem_wdata during the write strobe
        logic [4:0]  waddr;    // expected mem_addr during any strobe
    } vec_t;

    vec_t vt [22];

    task automatic run_vec(input int idx, input vec_t v);
        int  lat;
        int  nrd;
        int  nwr;
        logic [31:0] wseen;
        string pfx;
        pfx  = $sformatf("v%0d", idx);
        lat  = 0;
        nrd  = 0;
        nwr  = 0;
        wseen = 32'h0;
        n_vec++;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = v.we;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        chk({pfx, "_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) chk({pfx, "_strobe_overlap"}, 32'h1, 32'h0);
            if (mem_read || mem_write) chk({pfx, "_mem_addr"}, {27'h0, mem_addr}, {27'h0, v.waddr});
            if (mem_read)  nrd++;
            if (mem_write) begin nwr++; wseen = mem_wdata; end
            if (resp_valid) begin lat = c; break; end
        end
        chk({pfx, "_latency"}, lat, v.lat);
        chk({pfx, "_err"}, {31'h0, resp_err}, {31'h0, v.err});
        if (v.chk_rd) chk({pfx, "_rdata"}, resp_rdata, v.rdata);
        chk({pfx, "_nread"}, nrd, v.nrd);
        chk({pfx, "_nwrite"}, nwr, v.nwr);
        if (v.nwr > 0) chk({pfx, "_wdata"}, wseen, v.wword);
    endtask

    logic [31:0] qa [4];
    logic [31:0] qe [4];

    initial begin
        n_vec = 0; n_chk = 0; n_fail = 0;
        rst_n = 1'b0; tb_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;

        //        we  op      addr          wdata         chk rdata         err lat rd wr wword         waddr
        vt[0]  = '{1'b0, 3'b010, 32'h0000_000C, 32'h0, 1'b1, 32'h8899_AABB, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[1]  = '{1'b0, 3'b000, 32'h0000_000F, 32'h0, 1'b1, 32'hFFFF_FF88, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[2]  = '{1'b0, 3'b100, 32'h0000_000F, 32'h0, 1'b1, 32'h0000_0088, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[3]  = '{1'b0, 3'b001, 32'h0000_000E, 32'h0, 1'b1, 32'hFFFF_8899, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[4]  = '{1'b0, 3'b101, 32'h0000_000C, 32'h0, 1'b1, 32'h0000_AABB, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[5]  = '{1'b0, 3'b000, 32'h0000_000C, 32'h0, 1'b1, 32'hFFFF_FFBB, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[6]  = '{1'b1, 3'b000, 32'h0000_000D, 32'h1234_5677, 1'b0, 32'h0, 1'b0, 3, 1, 1, 32'h8899_77BB, 5'd3};
        vt[7]  = '{1'b0, 3'b010, 32'h0000_000C, 32'h0, 1'b1, 32'h8899_77BB, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[8]  = '{1'b0, 3'b010, 32'h0000_000E, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 5'd0};
        vt[9]  = '{1'b1, 3'b001, 32'h0000_0001, 32'hFFFF, 1'b1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 5'd0};
        vt[10] = '{1'b0, 3'b010, 32'h0000_000C, 32'h0, 1'b1, 32'h8899_77BB, 1'b0, 2, 1, 0, 32'h0, 5'd3};
        vt[11] = '{1'b0, 3'b010, 32'h0000_0080, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 5'd0};
        vt[12] = '{1'b0, 3'b011, 32'h0000_000C, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 5'd0};
        vt[13] = '{1'b1, 3'b010, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 2, 0, 1, 32'hDEAD_BEEF, 5'd5};
        vt[14] = '{1'b0, 3'b010, 32'h0000_0014, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'h0, 5'd5};
        vt[15] = '{1'b1, 3'b001, 32'h0000_0016, 32'h0000_CAFE, 1'b0, 32'h0, 1'b0, 3, 1, 1, 32'hCAFE_BEEF, 5'd5};
        vt[16] = '{1'b0, 3'b001, 32'h0000_0016, 32'h0, 1'b1, 32'hFFFF_CAFE, 1'b0, 2, 1, 0, 32'h0, 5'd5};
        vt[17] = '{1'b1, 3'b100, 32'h0000_0014, 32'h0000_0055, 1'b0, 32'h0, 1'b0, 3, 1, 1, 32'hCAFE_BE55, 5'd5};
        vt[18] = '{1'b0, 3'b101, 32'h0000_0014, 32'h0, 1'b1, 32'h0000_BE55, 1'b0, 2, 1, 0, 32'h0, 5'd5};
        vt[19] = '{1'b0, 3'b000, 32'h0000_0017, 32'h0, 1'b1, 32'hFFFF_FFCA, 1'b0, 2, 1, 0, 32'h0, 5'd5};
        vt[20] = '{1'b0, 3'b010, 32'h0000_007C, 32'h0, 1'b1, 32'hA5A5_5A5A, 1'b0, 2, 1, 0, 32'h0, 5'd31};
        vt[21] = '{1'b0, 3'b010, 32'h8000_000C, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 5'd0};

        qa[0] = 32'h0000_000C; qe[0] = 32'h8899_77BB;
        qa[1] = 32'h0000_0014; qe[1] = 32'hCAFE_BE55;
        qa[2] = 32'h0000_0000; qe[2] = 32'h0123_4567;
        qa[3] = 32'h0000_001C; qe[3] = 32'h7654_3210;

        // Reset and preload
        repeat (3) @(posedge clk);
        @(negedge clk);
        tb_init = 1'b0;
        rst_n   = 1'b1;
        n_vec++;
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_mem_read",   {31'h0, mem_read},   32'h0);
        chk("rst_mem_write",  {31'h0, mem_write},  32'h0);
        chk("rst_mem_addr",   {27'h0, mem_addr},   32'h0);
        chk("rst_mem_wdata",  mem_wdata,           32'h0);

        for (int i = 0; i < 22; i++) run_vec(i, vt[i]);

        // Back-to-back word loads with req_valid held high
        begin
            int idx;
            int nresp;
            int last;
            idx = 0; nresp = 0; last = 0;
            n_vec++;
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = qa[0];
            for (int c = 1; c <= 40 && nresp < 4; c++) begin
                @(negedge clk);
                if (resp_valid) begin
                    chk($sformatf("q%0d_rdata", nresp), resp_rdata, qe[nresp]);
                    chk($sformatf("q%0d_err", nresp), {31'h0, resp_err}, 32'h0);
                    if (nresp > 0) chk($sformatf("q%0d_spacing", nresp), c - last, 3);
                    last = c;
                    nresp++;
                end
                if (mem_read || resp_valid) chk("q_ready_busy", {31'h0, req_ready}, 32'h0);
                if (req_ready && idx < 4) begin
                    @(posedge clk); #1;
                    idx++;
                    if (idx < 4) req_addr = qa[idx];
                    else         req_valid = 1'b0;
                end
            end
            req_valid = 1'b0;
            chk("q_resp_count", nresp, 4);
            chk("q_accept_count", idx, 4);
        end

        // Reset asserted during the WRITE of a sub-word store
        n_vec++;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b001;
        req_addr = 32'h0000_000E; req_wdata = 32'h0000_CAFE;
        @(negedge clk);
        chk("r_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("r_read_cycle1", {31'h0, mem_read}, 32'h1);
        @(negedge clk);
        chk("r_write_cycle2", {31'h0, mem_write}, 32'h1);
        chk("r_wdata", mem_wdata, 32'hCAFE_77BB);
        #1 rst_n = 1'b0;
        #1;
        chk("r_write_drop",  {31'h0, mem_write},  32'h0);
        chk("r_read_low",    {31'h0, mem_read},   32'h0);
        chk("r_resp_valid",  {31'h0, resp_valid}, 32'h0);
        chk("r_resp_err",    {31'h0, resp_err},   32'h0);
        chk("r_resp_rdata",  resp_rdata,          32'h0);
        chk("r_mem_addr",    {27'h0, mem_addr},   32'h0);
        chk("r_mem_wdata",   mem_wdata,           32'h0);
        chk("r_ready_rst",   {31'h0, req_ready},  32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("r_no_resp", {31'h0, resp_valid}, 32'h0);
            chk("r_ready_after", {31'h0, req_ready}, 32'h1);
        end
        chk("r_mem_unchanged", mem[3], 32'h8899_77BB);

        // Memory word must still read back unchanged through the DUT
        run_vec(99, vt[7]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
